axis_stream_fifo: RTL and testbench
===================================

AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 The clock SHALL be S_AXIS_ACLK and the reset SHALL be S_AXIS_ARESETN; the block uses one clock, and reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 24: TDATA width in bits, valid range 1..64.
REQ-003 Parameter DEPTH, default 1280: storage entries, valid range 2..4096, power of two not required.
REQ-004 Parameter AFULL_THRESH, default DEPTH-16: level at or above which FIFO_AFULL is asserted.
REQ-005 Parameter AEMPTY_THRESH, default 16: level at or below which FIFO_AEMPTY is asserted.
REQ-006 Port S_AXIS_ACLK, input, 1: clock.
REQ-007 Port S_AXIS_ARESETN, input, 1: asynchronous active-low reset.
REQ-008 Port S_AXIS_TDATA, input, DATA_WIDTH: write data.
REQ-009 Port S_AXIS_TVALID, input, 1, and port S_AXIS_TLAST, input, 1: write valid and end-of-packet.
REQ-010 Port S_AXIS_TREADY, output, 1: the FIFO can accept a write.
REQ-011 Ports M_AXIS_TDATA, output, DATA_WIDTH, and M_AXIS_TLAST, output, 1: read data and end-of-packet.
REQ-012 Ports M_AXIS_TVALID, output, 1, and M_AXIS_TREADY, input, 1: read handshake.
REQ-013 Port FIFO_LEVEL, output, $clog2(DEPTH+1): entries held, including the output register.
REQ-014 Ports FIFO_AFULL, output, 1, and FIFO_AEMPTY, output, 1: threshold flags.

Function
REQ-015 A write SHALL occur on a clock edge with S_AXIS_TVALID=1 and S_AXIS_TREADY=1; each write stores {TLAST,TDATA}.
REQ-016 A read SHALL occur on a clock edge with M_AXIS_TVALID=1 and M_AXIS_TREADY=1.
REQ-017 S_AXIS_TREADY SHALL be 1 exactly when FIFO_LEVEL<DEPTH; it is registered and does not depend combinationally on M_AXIS_TREADY.
REQ-018 The output SHALL be first-word-fall-through: a word written into an empty FIFO at edge N drives M_AXIS_TVALID=1 after edge N+1, a latency of 1 cycle.
REQ-019 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA and M_AXIS_TLAST SHALL hold stable.
REQ-020 With a sustained write and read, throughput SHALL be 1 word per cycle in both directions.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0, which covers non-power-of-two DEPTH.
REQ-022 On a simultaneous write and read edge, FIFO_LEVEL SHALL be unchanged.
REQ-023 When the FIFO is full, a write SHALL NOT be accepted even if a read occurs on the same edge; S_AXIS_TREADY rises on the following cycle.
REQ-024 FIFO_LEVEL, FIFO_AFULL and FIFO_AEMPTY SHALL be registered and updated on the same edge as the handshake that changes the level.
REQ-025 Data order SHALL be strictly FIFO, and no word is ever lost or duplicated.

Reset
REQ-026 Asserting S_AXIS_ARESETN low SHALL immediately drive the following outputs: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, FIFO_LEVEL=0, FIFO_AFULL=0, FIFO_AEMPTY=1; it also clears both pointers.
REQ-027 S_AXIS_TREADY SHALL rise on the first clock edge after reset deassertion.
REQ-028 A reset asserted mid-operation SHALL discard all stored contents; RAM contents are not cleared.

Configuration
REQ-029 With macro AXIS_FIFO_PKT_MODE_EN defined, M_AXIS_TVALID SHALL assert only when one of the following holds:
- at least one complete packet (a word with TLAST=1) is stored;
- a packet is already partially read out;
- the FIFO is full, which prevents deadlock on packets longer than DEPTH.
REQ-030 In packet mode, a registered complete-packet counter SHALL increment on a write with TLAST=1 and decrement on a read with TLAST=1; on a simultaneous increment and decrement it is unchanged.
REQ-031 Without AXIS_FIFO_PKT_MODE_EN, no packet counter SHALL exist and the FIFO behaves as in REQ-018.

Structure
REQ-032 The shared package axis_fifo_pkg SHALL hold the default width, depth and thresholds, and the LEVEL_W calculation function.
REQ-033 Storage SHALL be the sub-module axis_fifo_ram: simple dual-port, synchronous read, DEPTH x (DATA_WIDTH+1), inferable as block RAM.

Verification
REQ-034 Reset, then one word 0xABCDEF written with TLAST=0 -> M_AXIS_TVALID=1 one cycle later, TDATA=0xABCDEF, FIFO_LEVEL=1.
REQ-035 M_AXIS_TREADY=0, 1500 writes offered -> 1280 accepted, S_AXIS_TREADY=0, FIFO_LEVEL=1280, FIFO_AFULL=1; then drain -> all 1280 words read in order.
REQ-036 Write and read continuously for 3000 cycles at DEPTH=1280 (pointer wrap) -> no gaps, FIFO_LEVEL constant, data sequence matches the scoreboard.
REQ-037 Full FIFO with a simultaneous read and write offered -> the read is accepted, the write is refused that cycle, and FIFO_LEVEL=1279.
REQ-038 With AXIS_FIFO_PKT_MODE_EN defined, write 10 words with TLAST only on the 10th -> M_AXIS_TVALID=0 until the 10th write, then 10 words are read back-to-back.
REQ-039 Reset pulsed with FIFO_LEVEL=500 -> all outputs at reset values, and the next write appears as the first output.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared defaults and sizing helpers for the AXI-Stream FIFO.
// Packet mode is enabled by defining AXIS_FIFO_PKT_MODE_EN.
package axis_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 24;
  localparam int DEF_DEPTH         = 1280;
  localparam int DEF_AFULL_MARGIN  = 16;
  localparam int DEF_AFULL_THRESH  = DEF_DEPTH - DEF_AFULL_MARGIN;
  localparam int DEF_AEMPTY_THRESH = 16;

  // Width needed to count 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage with a registered read port, written so that
// synthesis maps it onto block RAM.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO; the RAM read register doubles as
// the output stage. Define AXIS_FIFO_PKT_MODE_EN to hold TVALID until a whole packet is stored.
module axis_stream_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                        S_AXIS_ACLK,
  input  logic                        S_AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic                        S_AXIS_TVALID,
  input  logic                        S_AXIS_TLAST,
  output logic                        S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic                        M_AXIS_TLAST,
  output logic                        M_AXIS_TVALID,
  input  logic                        M_AXIS_TREADY,
  output logic [level_w(DEPTH)-1:0]   FIFO_LEVEL,
  output logic                        FIFO_AFULL,
  output logic                        FIFO_AEMPTY
);

  localparam int LEVEL_W = level_w(DEPTH);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int WORD_W  = DATA_WIDTH + 1;

  localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] AFULL_L  = LEVEL_W'(AFULL_THRESH);
  localparam logic [LEVEL_W-1:0] AEMPTY_L = LEVEL_W'(AEMPTY_THRESH);
  localparam logic [LEVEL_W-1:0] ONE_L    = LEVEL_W'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d, ram_cnt_q, ram_cnt_d;
  logic               out_full_q, out_full_d;
  logic               s_ready_q, s_ready_d;
  logic               afull_q, afull_d, aempty_q, aempty_d;
  logic               wr_en, rd_en, load, m_valid;
  logic [WORD_W-1:0]  ram_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_en = S_AXIS_TVALID & s_ready_q;
  assign rd_en = m_valid & M_AXIS_TREADY;
  // Refill the output stage whenever it is empty or being consumed this cycle.
  assign load  = (ram_cnt_q != '0) & (~out_full_q | rd_en);

  always_comb begin
    level_d = level_q;
    if (wr_en & ~rd_en)      level_d = level_q + ONE_L;
    else if (~wr_en & rd_en) level_d = level_q - ONE_L;
    ram_cnt_d = ram_cnt_q;
    if (wr_en & ~load)       ram_cnt_d = ram_cnt_q + ONE_L;
    else if (~wr_en & load)  ram_cnt_d = ram_cnt_q - ONE_L;
    out_full_d = load | (out_full_q & ~rd_en);
    wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = load  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    s_ready_d  = level_d < DEPTH_L;
    afull_d    = level_d >= AFULL_L;
    aempty_d   = level_d <= AEMPTY_L;
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ram_cnt_q  <= '0;
      out_full_q <= 1'b0;
      s_ready_q  <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ram_cnt_q  <= ram_cnt_d;
      out_full_q <= out_full_d;
      s_ready_q  <= s_ready_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [LEVEL_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic               mid_pkt_q, mid_pkt_d;
  logic               pkt_in, pkt_out;

  assign pkt_in  = wr_en & S_AXIS_TLAST;
  assign pkt_out = rd_en & M_AXIS_TLAST;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_in & ~pkt_out)      pkt_cnt_d = pkt_cnt_q + ONE_L;
    else if (~pkt_in & pkt_out) pkt_cnt_d = pkt_cnt_q - ONE_L;
    mid_pkt_d = rd_en ? ~M_AXIS_TLAST : mid_pkt_q;
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      pkt_cnt_q <= '0;
      mid_pkt_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      mid_pkt_q <= mid_pkt_d;
    end
  end

  // A full FIFO releases data regardless, so packets longer than DEPTH cannot deadlock.
  assign m_valid = out_full_q & ((pkt_cnt_q != '0) | mid_pkt_q | (level_q == DEPTH_L));
`else
  assign m_valid = out_full_q;
`endif

  axis_fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (S_AXIS_ACLK),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .re    (load),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = out_full_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
  assign M_AXIS_TLAST  = out_full_q & ram_rdata[DATA_WIDTH];
  assign FIFO_LEVEL    = level_q;
  assign FIFO_AFULL    = afull_q;
  assign FIFO_AEMPTY   = aempty_q;

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed and randomized bench for axis_stream_fifo against a queue-based model.
module tb_axis_stream_fifo;

  localparam int DW     = 24;
  localparam int DEPTH  = 1280;
  localparam int AFULL  = DEPTH - 16;
  localparam int AEMPTY = 16;
  localparam int LW     = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast, m_tvalid, m_tready;
  logic [LW-1:0] fifo_level;
  logic          fifo_afull, fifo_aempty;

  axis_stream_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .FIFO_LEVEL     (fifo_level),
    .FIFO_AFULL     (fifo_afull),
    .FIFO_AEMPTY    (fifo_aempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            wc;
  } ent_t;

  ent_t mq[$];
  int   cyc      = 0;
  bit   armed    = 0;
  bit   mid_m    = 0;
  int   n_last_m = 0;
  int   n_rd_obs = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return armed && (mq.size() < DEPTH);
  endfunction

  // A stored word becomes visible one edge after the edge that wrote it.
  function automatic bit exp_valid();
    if (mq.size() == 0) return 1'b0;
    if (mq[0].wc >= cyc) return 1'b0;
`ifdef AXIS_FIFO_PKT_MODE_EN
    return (n_last_m > 0) || mid_m || (mq.size() == DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_outputs();
    chk("tready", s_tready, exp_ready());
    chk("tvalid", m_tvalid, exp_valid());
    chk("level", fifo_level, mq.size());
    chk("afull", fifo_afull, mq.size() >= AFULL);
    chk("aempty", fifo_aempty, mq.size() <= AEMPTY);
    if (exp_valid()) begin
      chk("tdata", m_tdata, mq[0].d);
      chk("tlast", m_tlast, mq[0].l);
    end
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] d, input logic l, input logic mr);
    bit   wr, rd, lv;
    ent_t e;
    s_tvalid = sv;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = mr;
    check_outputs();
    wr = sv && exp_ready();
    rd = mr && exp_valid();
    if (m_tvalid === 1'b1 && mr) n_rd_obs++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      lv = mq[0].l;
      void'(mq.pop_front());
      mid_m = !lv;
      if (lv) n_last_m--;
    end
    if (wr) begin
      e.d  = d;
      e.l  = l;
      e.wc = cyc;
      mq.push_back(e);
      if (l) n_last_m++;
    end
    armed = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    mq.delete();
    armed    = 1'b0;
    mid_m    = 1'b0;
    n_last_m = 0;
    chk("rst_tready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_afull", fifo_afull, 0);
    chk("rst_aempty", fifo_aempty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tready_hold", s_tready, 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_tready_rise", s_tready, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    pulse_reset();

    // Single word, first-word-fall-through latency.
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    chk("t034_valid_early", m_tvalid, 0);
    chk("t034_level", fifo_level, 1);
    step(1'b0, '0, 1'b0, 1'b0);
`ifndef AXIS_FIFO_PKT_MODE_EN
    chk("t034_valid", m_tvalid, 1);
    chk("t034_data", m_tdata, 24'hABCDEF);
`endif

    // Fill past capacity with the reader stalled, then drain.
    for (int i = 0; i < 1500; i++) step(1'b1, DW'($urandom()), 1'b0, 1'b0);
    chk("t035_level_full", fifo_level, DEPTH);
    chk("t035_tready_low", s_tready, 0);
    chk("t035_afull", fifo_afull, 1);
    n_rd_obs = 0;
    for (int i = 0; i < 1300; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("t035_reads", n_rd_obs, DEPTH);
    chk("t035_empty", fifo_level, 0);

    // Sustained streaming across pointer wrap.
    for (int i = 0; i < 3000; i++) begin
      if (i == 10) n_rd_obs = 0;
      step(1'b1, DW'($urandom()), ($urandom_range(7) == 0), 1'b1);
    end
`ifndef AXIS_FIFO_PKT_MODE_EN
    chk("t036_reads", n_rd_obs, 2990);
    chk("t036_level", fifo_level, 2);
`endif

    // Full FIFO: read accepted, write refused on the same edge.
    for (int i = 0; i < 1300; i++) step(1'b1, DW'($urandom()), (i % 4 == 3), 1'b0);
    chk("t037_full", fifo_level, DEPTH);
    n_rd_obs = 0;
    step(1'b1, DW'($urandom()), 1'b0, 1'b1);
    chk("t037_read", n_rd_obs, 1);
    chk("t037_level", fifo_level, DEPTH - 1);
    chk("t037_tready", s_tready, 1);

    // Reset mid-operation with 500 words held.
    for (int i = 0; i < 2000 && mq.size() > 500; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("t039_level500", fifo_level, 500);
    pulse_reset();
    step(1'b1, 24'h123456, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t039_valid", m_tvalid, 1);
    chk("t039_data", m_tdata, 24'h123456);

    // Random traffic on both sides.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(9) < 7), DW'($urandom()), ($urandom_range(3) == 0),
           ($urandom_range(9) < 6));

`ifdef AXIS_FIFO_PKT_MODE_EN
    // Packet gating: nothing visible until the TLAST word lands.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(32'h100 + i), (i == 9), 1'b1);
      chk("t038_gate", m_tvalid, (i == 9));
    end
    n_rd_obs = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("t038_reads", n_rd_obs, 10);
    chk("t038_empty", fifo_level, 0);
`endif

    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
